// File: rtl/seg_dyn_bcd_disp.sv
// Six-digit scanned seven-segment display with a sequential shift-add-3 BCD converter.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
module seg_dyn_bcd_disp #(
   parameter int CNT_MAX = 49999
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [19:0] data,
   input  logic [5:0]  point,
   input  logic        sign,
   input  logic        seg_en,
   output logic [5:0]  sel,
   output logic [7:0]  seg
);

   localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t       r_state;
   logic [4:0]   r_bitCnt;
   logic [19:0]  r_bin;
   logic [23:0]  r_bcd;
   logic         r_capSign;
   logic [5:0]   r_capPoint;
   logic [23:0]  r_dispBcd;
   logic         r_dispSign;
   logic [5:0]   r_dispPoint;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]   r_idx;

   logic [23:0]  w_adj;
   logic [2:0]   w_msd;
   logic [2:0]   w_minusPos;
   logic [3:0]   w_nib;
   logic [7:0]   w_segRaw;
   logic [7:0]   w_seg;
   logic [5:0]   w_sel;

   function automatic logic [7:0] decodeDigit(input logic [3:0] nib);
      case (nib)
         4'd0:    decodeDigit = 8'hC0;
         4'd1:    decodeDigit = 8'hF9;
         4'd2:    decodeDigit = 8'hA4;
         4'd3:    decodeDigit = 8'hB0;
         4'd4:    decodeDigit = 8'h99;
         4'd5:    decodeDigit = 8'h92;
         4'd6:    decodeDigit = 8'h82;
         4'd7:    decodeDigit = 8'hF8;
         4'd8:    decodeDigit = 8'h80;
         4'd9:    decodeDigit = 8'h90;
         default: decodeDigit = 8'hFF;
      endcase
   endfunction

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 6; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) begin
            w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   // Free-running converter: one capture cycle, 20 shift cycles, one latch cycle.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= S_IDLE;
         r_bitCnt    <= 5'd0;
         r_bin       <= 20'd0;
         r_bcd       <= 24'd0;
         r_capSign   <= 1'b0;
         r_capPoint  <= 6'd0;
         r_dispBcd   <= 24'd0;
         r_dispSign  <= 1'b0;
         r_dispPoint <= 6'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_bin      <= (data > 20'd999999) ? 20'd999999 : data;
               r_bcd      <= 24'd0;
               r_bitCnt   <= 5'd0;
               r_capSign  <= sign;
               r_capPoint <= point;
               r_state    <= S_SHIFT;
            end
            S_SHIFT: begin
               {r_bcd, r_bin} <= {w_adj[22:0], r_bin, 1'b0};
               r_bitCnt       <= r_bitCnt + 5'd1;
               if (r_bitCnt == 5'd19) begin
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: begin
               r_dispBcd   <= r_bcd;
               r_dispSign  <= r_capSign;
               r_dispPoint <= r_capPoint;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt <= '0;
         r_idx <= 3'd0;
      end else if (r_cnt == CNT_W'(CNT_MAX)) begin
         r_cnt <= '0;
         r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // w_msd is the leftmost digit that must stay visible; everything left of it is blank.
   always_comb begin
`ifdef SEG_BLANK_EN
      w_msd = 3'd0;
      for (int i = 1; i < 6; i++) begin
         if ((r_dispBcd[i*4 +: 4] != 4'd0) || r_dispPoint[i]) begin
            w_msd = 3'(i);
         end
      end
`else
      w_msd = 3'd5;
`endif
      w_minusPos = (w_msd == 3'd5) ? 3'd5 : w_msd + 3'd1;
   end

   always_comb begin
      case (r_idx)
         3'd0:    w_nib = r_dispBcd[3:0];
         3'd1:    w_nib = r_dispBcd[7:4];
         3'd2:    w_nib = r_dispBcd[11:8];
         3'd3:    w_nib = r_dispBcd[15:12];
         3'd4:    w_nib = r_dispBcd[19:16];
         default: w_nib = r_dispBcd[23:20];
      endcase
      if (r_dispSign && (r_idx == w_minusPos)) begin
         w_segRaw = 8'hBF;
      end else if (r_idx > w_msd) begin
         w_segRaw = 8'hFF;
      end else begin
         w_segRaw = decodeDigit(w_nib);
      end
      w_seg = {w_segRaw[7] & ~r_dispPoint[r_idx], w_segRaw[6:0]};
      w_sel = 6'd1 << r_idx;
   end

   // Outputs are registered so sel and seg move together one cycle after the index.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sel <= 6'd0;
         seg <= 8'hFF;
      end else if (seg_en) begin
         sel <= w_sel;
         seg <= w_seg;
      end else begin
         sel <= 6'd0;
         seg <= 8'hFF;
      end
   end

endmodule

// File: tb/tb_seg_dyn_bcd_disp.sv
// Self-checking bench for seg_dyn_bcd_disp (short dwell); follows SEG_BLANK_EN like the DUT.
`timescale 1ns/1ps
module tb_seg_dyn_bcd_disp;

   localparam int CNT_MAX = 3;
   localparam int DWELL   = CNT_MAX + 1;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [19:0] data;
   logic [5:0]  point;
   logic        sign;
   logic        seg_en;
   logic [5:0]  sel;
   logic [7:0]  seg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [19:0]     data;
      logic [5:0]      point;
      logic            sign;
      logic [5:0][7:0] expSeg;
   } vec_t;

   typedef struct packed {
      logic [5:0] sel;
      logic [7:0] seg;
   } obs_t;

   vec_t vecs[7];
   obs_t expQ[$];

   seg_dyn_bcd_disp #(.CNT_MAX(CNT_MAX)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .data     (data),
      .point    (point),
      .sign     (sign),
      .seg_en   (seg_en),
      .sel      (sel),
      .seg      (seg)
   );

   // 50 MHz clock
   always #10 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [5:0] expSel, input logic [7:0] expSegV);
      checks++;
      if (sel !== expSel || seg !== expSegV) begin
         errors++;
         $display("[TB] FAIL %s: got sel=%b seg=%h, want sel=%b seg=%h", name, sel, seg, expSel, expSegV);
      end
   endtask

   task automatic applyStimulus(input logic [19:0] d, input logic [5:0] p, input logic s);
      @(negedge sys_clk);
      data  = d;
      point = p;
      sign  = s;
   endtask

   // Returns on the negedge where digit 0 first becomes visible (first dwell cycle).
   task automatic syncDigit0(output bit ok);
      logic [5:0] prev;
      ok   = 1'b0;
      prev = sel;
      for (int k = 0; k < 60; k++) begin
         @(negedge sys_clk);
         if (sel == 6'b000001 && prev != 6'b000001) begin
            ok = 1'b1;
            break;
         end
         prev = sel;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL sync_digit0: got sel=%b, want a transition to 000001", sel);
      end
   endtask

   initial begin
      bit          ok;
      obs_t        e;
      logic [7:0]  expV;
      logic [5:0]  expSel;

      vecs[0] = '{20'd123456, 6'b000000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
      vecs[2] = '{20'd1048575, 6'b000000, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
      vecs[5] = '{20'd999999, 6'b100000, 1'b1, {8'h3F, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
`ifdef SEG_BLANK_EN
      vecs[1] = '{20'd255, 6'b000010, 1'b1, {8'hFF, 8'hFF, 8'hBF, 8'hA4, 8'h12, 8'h92}};
      vecs[3] = '{20'd0, 6'b000000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
      vecs[4] = '{20'd0, 6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0}};
      vecs[6] = '{20'd7, 6'b000100, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hF8}};
`else
      vecs[1] = '{20'd255, 6'b000010, 1'b1, {8'hBF, 8'hC0, 8'hC0, 8'hA4, 8'h12, 8'h92}};
      vecs[3] = '{20'd0, 6'b000000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
      vecs[4] = '{20'd0, 6'b000000, 1'b1, {8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
      vecs[6] = '{20'd7, 6'b000100, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hC0, 8'hF8}};
`endif

      sys_rst_n = 1'b0;
      data      = 20'd0;
      point     = 6'd0;
      sign      = 1'b0;
      seg_en    = 1'b1;
      #1000;
      checkOutput("reset_idle", 6'b000000, 8'hFF);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge sys_clk);
         if (sel == 6'b000001) break;
      end
      checkOutput("post_reset_digit0", 6'b000001, 8'hC0);

      // Table vectors: expected scan pushed when applied, popped per digit dwell.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].data, vecs[v].point, vecs[v].sign);
         repeat (50) @(negedge sys_clk);
         for (int d = 0; d < 6; d++) begin
            expQ.push_back('{sel: 6'(1 << d), seg: vecs[v].expSeg[d]});
         end
         syncDigit0(ok);
         for (int d = 0; d < 6; d++) begin
            e = expQ.pop_front();
            for (int k = 0; k < DWELL; k++) begin
               if (ok && !(d == 0 && k == 0)) @(negedge sys_clk);
               if (ok) checkOutput($sformatf("vec%0d_dig%0d_cyc%0d", v, d, k), e.sel, e.seg);
            end
         end
      end

      // Reset at an arbitrary phase, then watch conversion latency and data changes mid-SHIFT.
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      data      = 20'd111111;
      point     = 6'd0;
      sign      = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int j = 1; j <= 46; j++) begin
         @(negedge sys_clk);
         expSel = 6'(1 << (((j - 1) / DWELL) % 6));
         if (j <= 22) begin
`ifdef SEG_BLANK_EN
            expV = (expSel == 6'b000001) ? 8'hC0 : 8'hFF;
`else
            expV = 8'hC0;
`endif
         end else if (j <= 44) begin
            expV = 8'hF9;
         end else begin
            expV = 8'h80;
         end
         checkOutput($sformatf("latency_cyc%0d", j), expSel, expV);
         if (j == 5) data = 20'd888888;
      end

      // seg_en off mid-dwell, then back on without disturbing the scan position.
      applyStimulus(20'd123456, 6'd0, 1'b0);
      repeat (50) @(negedge sys_clk);
      syncDigit0(ok);
      if (ok) begin
         checkOutput("en_dig0_cyc0", 6'b000001, 8'h82);
         @(negedge sys_clk);
         seg_en = 1'b0;
         @(negedge sys_clk);
         checkOutput("en_off_next_cycle", 6'b000000, 8'hFF);
         for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("en_off_hold%0d", k), 6'b000000, 8'hFF);
         end
         seg_en = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("en_on_dig2_cyc%0d", k + 1), 6'b000100, 8'h99);
         end
         @(negedge sys_clk);
         checkOutput("en_on_dig3", 6'b001000, 8'hB0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
